vector_scalar_alu: RTL

VECTOR_SCALAR_ALU -- requirements
Module: vector_scalar_alu

---
 rtl/vector_scalar_alu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vector_scalar_alu.sv
// Two-stage saturating vector/scalar ALU with valid/ready operand join.
// Stage 1 holds raw wide lane results; stage 2 clamps and drives outputs.
module vector_scalar_alu #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] a_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [LANES*DATA_WIDTH-1:0] b_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [2:0]                  op,
    output logic [LANES*DATA_WIDTH-1:0] res_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_sat,
    output logic                        res_op_err,
    output logic [15:0]                 sat_count,
    input  logic                        sat_clear
);

    localparam int W  = DATA_WIDTH;
    localparam int RW = 2 * DATA_WIDTH;

    localparam logic signed [RW-1:0] MAX_V =
        {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V =
        {{(W+1){1'b1}}, {(W-1){1'b0}}};

    logic advance;
    logic accept;

    assign advance = !res_valid || res_ready;
    assign accept  = a_valid && b_valid && advance;
    assign a_ready = advance && b_valid;
    assign b_ready = advance && a_valid;

    function automatic logic signed [RW-1:0] lane_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [2:0]   sel
    );
        logic signed [RW-1:0] ax;
        logic signed [RW-1:0] bx;
        logic signed [RW-1:0] prod;
        ax   = {{W{a[W-1]}}, a};
        bx   = {{W{b[W-1]}}, b};
        prod = ax * bx;
        unique case (sel)
            3'd0:    lane_op = ax + bx;
            3'd1:    lane_op = ax - bx;
            3'd2:    lane_op = prod >>> FRAC_BITS;
            3'd3:    lane_op = (ax > bx) ? ax : bx;
            3'd4:    lane_op = (ax < bx) ? ax : bx;
            default: lane_op = '0;
        endcase
    endfunction

    logic [LANES-1:0][RW-1:0] raw_d;
    logic [LANES-1:0][RW-1:0] s1_raw;
    logic                     s1_valid;
    logic                     s1_err;

    always_comb begin
        raw_d = '0;
        for (int i = 0; i < LANES; i++) begin
            raw_d[i] = lane_op(a_data[i*W +: W],
                               b_data[i*W +: W], op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_raw   <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_err   <= op > 3'd4;
            s1_raw   <= raw_d;
        end
    end

    logic [LANES*W-1:0] sat_data;
    logic [LANES-1:0]   lane_sat;

    always_comb begin
        sat_data = '0;
        lane_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            if ($signed(s1_raw[i]) > MAX_V) begin
                sat_data[i*W +: W] = MAX_V[W-1:0];
                lane_sat[i]        = 1'b1;
            end else if ($signed(s1_raw[i]) < MIN_V) begin
                sat_data[i*W +: W] = MIN_V[W-1:0];
                lane_sat[i]        = 1'b1;
            end else begin
                sat_data[i*W +: W] = s1_raw[i][W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_sat    <= 1'b0;
            res_op_err <= 1'b0;
        end else if (advance) begin
            res_valid  <= s1_valid;
            res_data   <= sat_data;
            res_sat    <= s1_valid && (|lane_sat);
            res_op_err <= s1_valid && s1_err;
        end
    end

    // Counts results that actually leave, so stalled beats count once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (res_valid && res_ready && res_sat &&
                     sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule
